// File: rtl/fifo_scoreboard_checker_if.sv
// Observation bus for fifo_scoreboard_checker: FIFO push/pop events in, checker status out.
// The master drives the observed events; the slave is the checker.
interface fifo_scoreboard_checker_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
);
   logic                     i_cg;
   logic                     i_pushValid;
   logic [WIDTH-1:0]         i_pushData;
   logic                     i_popValid;
   logic [WIDTH-1:0]         i_popData;
   logic                     i_clear;
   logic [$clog2(DEPTH):0]   o_nOutstanding;
   logic [31:0]              o_nChecked;
   logic [15:0]              o_nErrors;
   logic [1:0]               o_state;
   logic                     o_mismatch;
   logic                     o_underflow;
   logic                     o_overflow;
   logic [WIDTH-1:0]         o_errExpected;
   logic [WIDTH-1:0]         o_errActual;

   modport master (
      output i_cg, i_pushValid, i_pushData, i_popValid, i_popData, i_clear,
      input  o_nOutstanding, o_nChecked, o_nErrors, o_state,
      input  o_mismatch, o_underflow, o_overflow, o_errExpected, o_errActual
   );

   modport slave (
      input  i_cg, i_pushValid, i_pushData, i_popValid, i_popData, i_clear,
      output o_nOutstanding, o_nChecked, o_nErrors, o_state,
      output o_mismatch, o_underflow, o_overflow, o_errExpected, o_errActual
   );
endinterface

// File: rtl/fifo_scoreboard_checker.sv
// Scoreboard that mirrors a FIFO's pushes and checks its pops in order, with sticky error flags.
// Define FIFO_SCOREBOARD_CHECKER_CAPTURE_EN to capture the data of the first mismatch.
module fifo_scoreboard_checker #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input logic                   i_clk,
   input logic                   i_rst,
   fifo_scoreboard_checker_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StActive = 2'd1,
      StFailed = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [31:0]      n_checked_q, n_checked_d;
   logic [15:0]      n_errors_q, n_errors_d;
   logic             mismatch_q, mismatch_d;
   logic             underflow_q, underflow_d;
   logic             overflow_q, overflow_d;

   logic             push, pop, empty, full;
   logic             wr_en, cmp, mism, err_under, err_over, err;
   logic [WIDTH-1:0] exp_data;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      n_checked_d = n_checked_q;
      n_errors_d  = n_errors_q;
      mismatch_d  = mismatch_q;
      underflow_d = underflow_q;
      overflow_d  = overflow_q;
      wr_en       = 1'b0;
      cmp         = 1'b0;
      err_under   = 1'b0;
      err_over    = 1'b0;
      exp_data    = mem[rd_ptr_q];

      push  = bus.i_cg & bus.i_pushValid;
      pop   = bus.i_cg & bus.i_popValid;
      empty = (count_q == '0);
      full  = (count_q == CW'(DEPTH));

      if (pop) begin
         if (empty) begin
            // Empty queue with a same-cycle push: compare straight against the pushed data
            if (push) begin
               cmp      = 1'b1;
               exp_data = bus.i_pushData;
            end else begin
               err_under = 1'b1;
            end
         end else begin
            cmp      = 1'b1;
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (push) wr_en = 1'b1;
            else      count_d = count_q - CW'(1);
         end
      end else if (push) begin
         if (full) begin
            err_over = 1'b1;
         end else begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
         end
      end

      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);

      mism = cmp && (exp_data != bus.i_popData);
      err  = err_under | err_over | mism;

      if (cmp) n_checked_d = n_checked_q + 32'd1;
      if (err && (n_errors_q != 16'hFFFF)) n_errors_d = n_errors_q + 16'd1;
      mismatch_d  = mismatch_q | mism;
      underflow_d = underflow_q | err_under;
      overflow_d  = overflow_q | err_over;

      unique case (state_q)
         StIdle, StActive: state_d = (count_d != '0) ? StActive : StIdle;
         StFailed:         state_d = StFailed;
         default:          state_d = StIdle;
      endcase
      if (err) state_d = StFailed;

      if (bus.i_clear) begin
         wr_en       = 1'b0;
         state_d     = StIdle;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         n_checked_d = '0;
         n_errors_d  = '0;
         mismatch_d  = 1'b0;
         underflow_d = 1'b0;
         overflow_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         n_checked_q <= '0;
         n_errors_q  <= '0;
         mismatch_q  <= 1'b0;
         underflow_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         n_checked_q <= n_checked_d;
         n_errors_q  <= n_errors_d;
         mismatch_q  <= mismatch_d;
         underflow_q <= underflow_d;
         overflow_q  <= overflow_d;
      end
   end

   // Storage is not reset; the pointers and count define what is valid
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_ptr_q] <= bus.i_pushData;
   end

`ifdef FIFO_SCOREBOARD_CHECKER_CAPTURE_EN
   logic [WIDTH-1:0] err_exp_q, err_act_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         err_exp_q <= '0;
         err_act_q <= '0;
      end else if (bus.i_clear) begin
         err_exp_q <= '0;
         err_act_q <= '0;
      end else if (mism && !mismatch_q) begin
         err_exp_q <= exp_data;
         err_act_q <= bus.i_popData;
      end
   end

   assign bus.o_errExpected = err_exp_q;
   assign bus.o_errActual   = err_act_q;
`else
   assign bus.o_errExpected = '0;
   assign bus.o_errActual   = '0;
`endif

   assign bus.o_nOutstanding = count_q;
   assign bus.o_nChecked     = n_checked_q;
   assign bus.o_nErrors      = n_errors_q;
   assign bus.o_state        = state_q;
   assign bus.o_mismatch     = mismatch_q;
   assign bus.o_underflow    = underflow_q;
   assign bus.o_overflow     = overflow_q;
endmodule

// File: tb/tb_fifo_scoreboard_checker.sv
// Bench for fifo_scoreboard_checker: directed scenarios then random traffic against a queue model.
module tb_fifo_scoreboard_checker;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;

   fifo_scoreboard_checker_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   fifo_scoreboard_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: a plain queue plus counters.
   logic [WIDTH-1:0] mq[$];
   int unsigned      m_checked;
   int unsigned      m_errors;
   bit               m_mis, m_und, m_ovf, m_failed;
   logic [WIDTH-1:0] m_exp, m_act;

   function automatic void m_reset();
      mq.delete();
      m_checked = 0;
      m_errors  = 0;
      m_mis = 0; m_und = 0; m_ovf = 0; m_failed = 0;
      m_exp = '0; m_act = '0;
   endfunction

   function automatic void m_err();
      if (m_errors < 65535) m_errors++;
      m_failed = 1;
   endfunction

   function automatic void m_cmp(logic [WIDTH-1:0] e, logic [WIDTH-1:0] a);
      m_checked++;
      if (e != a) begin
         if (!m_mis) begin
            m_exp = e;
            m_act = a;
         end
         m_mis = 1;
         m_err();
      end
   endfunction

   function automatic void m_step(bit cg, bit pv, logic [WIDTH-1:0] pd, bit ppv,
                                  logic [WIDTH-1:0] ppd, bit clr);
      logic [WIDTH-1:0] h;
      if (clr) begin
         m_reset();
      end else if (cg) begin
         if (ppv) begin
            if (mq.size() == 0) begin
               if (pv) m_cmp(pd, ppd);
               else begin m_und = 1; m_err(); end
            end else begin
               h = mq.pop_front();
               m_cmp(h, ppd);
               if (pv) mq.push_back(pd);
            end
         end else if (pv) begin
            if (mq.size() == DEPTH) begin m_ovf = 1; m_err(); end
            else mq.push_back(pd);
         end
      end
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] st;
      st = m_failed ? 32'd2 : ((mq.size() != 0) ? 32'd1 : 32'd0);
      chk("n_outstanding", 32'(bus.o_nOutstanding), 32'(mq.size()));
      chk("n_checked", bus.o_nChecked, m_checked);
      chk("n_errors", 32'(bus.o_nErrors), m_errors);
      chk("state", 32'(bus.o_state), st);
      chk("mismatch", 32'(bus.o_mismatch), 32'(m_mis));
      chk("underflow", 32'(bus.o_underflow), 32'(m_und));
      chk("overflow", 32'(bus.o_overflow), 32'(m_ovf));
`ifdef FIFO_SCOREBOARD_CHECKER_CAPTURE_EN
      chk("err_expected", 32'(bus.o_errExpected), 32'(m_exp));
      chk("err_actual", 32'(bus.o_errActual), 32'(m_act));
`else
      chk("err_expected", 32'(bus.o_errExpected), 32'd0);
      chk("err_actual", 32'(bus.o_errActual), 32'd0);
`endif
   endtask

   task automatic step(bit cg, bit pv, logic [WIDTH-1:0] pd, bit ppv, logic [WIDTH-1:0] ppd,
                       bit clr);
      bus.i_cg        = cg;
      bus.i_pushValid = pv;
      bus.i_pushData  = pd;
      bus.i_popValid  = ppv;
      bus.i_popData   = ppd;
      bus.i_clear     = clr;
      @(posedge i_clk);
      m_step(cg, pv, pd, ppv, ppd, clr);
      #1;
      check_all();
   endtask

   task automatic push(logic [WIDTH-1:0] d);
      step(1, 1, d, 0, '0, 0);
   endtask

   task automatic pop(logic [WIDTH-1:0] d);
      step(1, 0, '0, 1, d, 0);
   endtask

   task automatic clear();
      step(1, 0, '0, 0, '0, 1);
   endtask

   initial begin
      logic [WIDTH-1:0] pd, ppd;
      bit               pv, ppv, cg, clr;
      int unsigned      push_pct;

      bus.i_cg = 0; bus.i_pushValid = 0; bus.i_pushData = '0;
      bus.i_popValid = 0; bus.i_popData = '0; bus.i_clear = 0;
      m_reset();
      repeat (2) @(posedge i_clk);
      #1;
      check_all();
      @(negedge i_clk);
      i_rst = 1'b1;

      // In-order traffic
      push(8'h11); push(8'h22); push(8'h33);
      pop(8'h11); pop(8'h22); pop(8'h33);
      clear();

      // Data mismatch
      push(8'hA5);
      pop(8'h5A);
      clear();

      // Bypass compare on empty queue
      step(1, 1, 8'h3C, 1, 8'h3C, 0);
      clear();

      // Fill, overflow, then simultaneous push+pop while full
      for (int i = 0; i < DEPTH; i++) push(WIDTH'(8'h40 + i));
      push(8'hEE);
      step(1, 1, 8'h77, 1, 8'h40, 0);
      clear();

      // Underflow, then clear beats a same-cycle push
      pop(8'h99);
      step(1, 1, 8'h55, 0, '0, 1);

      // Clock gate blocks events; async reset mid-stream
      for (int i = 0; i < 5; i++) push(WIDTH'(8'h60 + i));
      step(0, 1, 8'hFF, 1, 8'h00, 0);
      step(0, 1, 8'h12, 0, '0, 0);
      @(negedge i_clk);
      #2;
      i_rst = 1'b0;
      m_reset();
      #1;
      check_all();
      @(negedge i_clk);
      i_rst = 1'b1;

      // Random traffic, phases biased toward filling or draining
      for (int i = 0; i < 600; i++) begin
         push_pct = ((i / 100) % 2 == 0) ? 70 : 30;
         cg  = ($urandom_range(9) != 0);
         pv  = ($urandom_range(99) < push_pct);
         ppv = ($urandom_range(99) < (100 - push_pct));
         pd  = WIDTH'($urandom);
         clr = ($urandom_range(79) == 0);
         if (mq.size() != 0) ppd = mq[0];
         else                ppd = pd;
         if ($urandom_range(15) == 0) ppd = ppd ^ WIDTH'(1 << $urandom_range(WIDTH - 1));
         step(cg, pv, pd, ppv, ppd, clr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
